// File: rtl/async_fifo_fwft_if.sv
// Handshake bundle for async_fifo_fwft: write-side and read-side request/status signals.
// The FIFO takes the slave modport; the producer/consumer logic takes master.
interface async_fifo_fwft_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wr_count;
    logic                  wr_overflow;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   rd_count;
    logic                  rd_underflow;

    modport master (
        output wr_en, wr_data, rd_en,
        input  wr_full, almost_full, wr_count, wr_overflow,
        input  rd_data, rd_valid, rd_empty, almost_empty, rd_count, rd_underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output wr_full, almost_full, wr_count, wr_overflow,
        output rd_data, rd_valid, rd_empty, almost_empty, rd_count, rd_underflow
    );
endinterface

// File: rtl/async_fifo_fwft.sv
// Dual-clock FIFO with gray-coded pointer crossing, per-side occupancy counts and an
// optional first-word-fall-through output register.
module async_fifo_fwft #(
    parameter int ADDR_WIDTH       = 4,
    parameter int DATA_WIDTH       = 8,
    parameter int SYNC_STAGES      = 2,
    parameter int FWFT             = 0,
    parameter int ALMOST_FULL_NUM  = (1 << ADDR_WIDTH) - 2,
    parameter int ALMOST_EMPTY_NUM = 2
) (
    input  logic wr_clk,
    input  logic wr_rstn,
    input  logic rd_clk,
    input  logic rd_rstn,
    async_fifo_fwft_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    typedef logic [ADDR_WIDTH:0] ptr_t;
    localparam ptr_t ONE     = ptr_t'(1);
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t AF_P    = ptr_t'(ALMOST_FULL_NUM);
    localparam ptr_t AE_P    = ptr_t'(ALMOST_EMPTY_NUM);

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    ptr_t wr_ptr_q, wr_ptr_d, wr_gray_q, rd_ptr_sync, wr_count;
    logic wr_full, wr_push, wr_overflow_q;
    ptr_t rd_ptr_q, rd_ptr_d, rd_gray_q, wr_ptr_sync, rd_avail, rd_count;
    logic rd_empty, rd_load, rd_valid_q, rd_underflow_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Each stage holds one flop of both synchronisers; stage 0 samples the far-side gray pointer.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            ptr_t rd_gray_wr_q;
            ptr_t wr_gray_rd_q;
            if (gi == 0) begin : g_first
                always_ff @(posedge wr_clk or negedge wr_rstn) begin
                    if (!wr_rstn) rd_gray_wr_q <= '0;
                    else          rd_gray_wr_q <= rd_gray_q;
                end
                always_ff @(posedge rd_clk or negedge rd_rstn) begin
                    if (!rd_rstn) wr_gray_rd_q <= '0;
                    else          wr_gray_rd_q <= wr_gray_q;
                end
            end else begin : g_next
                always_ff @(posedge wr_clk or negedge wr_rstn) begin
                    if (!wr_rstn) rd_gray_wr_q <= '0;
                    else          rd_gray_wr_q <= g_sync[gi-1].rd_gray_wr_q;
                end
                always_ff @(posedge rd_clk or negedge rd_rstn) begin
                    if (!rd_rstn) wr_gray_rd_q <= '0;
                    else          wr_gray_rd_q <= g_sync[gi-1].wr_gray_rd_q;
                end
            end
        end
    endgenerate

    assign rd_ptr_sync = gray2bin(g_sync[SYNC_STAGES-1].rd_gray_wr_q);
    assign wr_count    = wr_ptr_q - rd_ptr_sync;
    assign wr_full     = (wr_count == DEPTH_P);
    assign wr_push     = bus.wr_en && !wr_full;
    assign wr_ptr_d    = wr_push ? wr_ptr_q + ONE : wr_ptr_q;

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            wr_ptr_q      <= '0;
            wr_gray_q     <= '0;
            wr_overflow_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            wr_gray_q     <= bin2gray(wr_ptr_d);
            wr_overflow_q <= bus.wr_en && wr_full;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_push) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
    end

    assign wr_ptr_sync = gray2bin(g_sync[SYNC_STAGES-1].wr_gray_rd_q);
    assign rd_avail    = wr_ptr_sync - rd_ptr_q;

    // In FWFT mode the output register is a one-word stage in front of the array and counts as occupancy.
    always_comb begin
        rd_empty = (rd_avail == '0);
        rd_load  = bus.rd_en && !rd_empty;
        rd_count = rd_avail;
        if (FWFT != 0) begin
            rd_empty = !rd_valid_q;
            rd_load  = (rd_avail != '0) && (!rd_valid_q || bus.rd_en);
            rd_count = rd_avail + ptr_t'(rd_valid_q);
        end
    end

    assign rd_ptr_d = rd_load ? rd_ptr_q + ONE : rd_ptr_q;

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rd_ptr_q       <= '0;
            rd_gray_q      <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            rd_underflow_q <= 1'b0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            rd_gray_q      <= bin2gray(rd_ptr_d);
            rd_underflow_q <= bus.rd_en && rd_empty;
            if (rd_load) begin
                rd_data_q  <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
                rd_valid_q <= 1'b1;
            end else if (FWFT == 0 || bus.rd_en) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign bus.wr_full      = wr_full;
    assign bus.almost_full  = (wr_count >= AF_P);
    assign bus.wr_count     = wr_count;
    assign bus.wr_overflow  = wr_overflow_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_empty     = rd_empty;
    assign bus.almost_empty = (rd_count <= AE_P);
    assign bus.rd_count     = rd_count;
    assign bus.rd_underflow = rd_underflow_q;
endmodule

// File: tb/tb_async_fifo_fwft.sv
// Bench for async_fifo_fwft: one standard-mode and one FWFT instance, directed scenarios
// plus randomized CDC streams checked against a queue model.
`timescale 1ns/100ps
module tb_async_fifo_fwft;
    logic wr_clk = 1'b0;
    logic rd_clk = 1'b0;
    logic wr_rstn, rd_rstn;
    realtime wr_half = 5.0;
    realtime rd_half = 8.5;
    always #(wr_half) wr_clk = ~wr_clk;
    always #(rd_half) rd_clk = ~rd_clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];

    logic [1:0] wr_en_s, rd_en_s;
    logic [7:0] wr_data_s [2];
    logic [1:0] wr_full_o, almost_full_o, wr_overflow_o, rd_valid_o, rd_empty_o, almost_empty_o, rd_underflow_o;
    logic [4:0] wr_count_o [2];
    logic [4:0] rd_count_o [2];
    logic [7:0] rd_data_o [2];

    async_fifo_fwft_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus0 ();
    async_fifo_fwft_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus1 ();

    async_fifo_fwft #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .SYNC_STAGES(2), .FWFT(0)) u_std (
        .wr_clk(wr_clk), .wr_rstn(wr_rstn), .rd_clk(rd_clk), .rd_rstn(rd_rstn), .bus(bus0.slave));
    async_fifo_fwft #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .SYNC_STAGES(2), .FWFT(1)) u_fwft (
        .wr_clk(wr_clk), .wr_rstn(wr_rstn), .rd_clk(rd_clk), .rd_rstn(rd_rstn), .bus(bus1.slave));

    assign bus0.wr_en = wr_en_s[0];     assign bus1.wr_en = wr_en_s[1];
    assign bus0.wr_data = wr_data_s[0]; assign bus1.wr_data = wr_data_s[1];
    assign bus0.rd_en = rd_en_s[0];     assign bus1.rd_en = rd_en_s[1];
    assign wr_full_o      = {bus1.wr_full, bus0.wr_full};
    assign almost_full_o  = {bus1.almost_full, bus0.almost_full};
    assign wr_overflow_o  = {bus1.wr_overflow, bus0.wr_overflow};
    assign rd_valid_o     = {bus1.rd_valid, bus0.rd_valid};
    assign rd_empty_o     = {bus1.rd_empty, bus0.rd_empty};
    assign almost_empty_o = {bus1.almost_empty, bus0.almost_empty};
    assign rd_underflow_o = {bus1.rd_underflow, bus0.rd_underflow};
    assign wr_count_o[0] = bus0.wr_count; assign wr_count_o[1] = bus1.wr_count;
    assign rd_count_o[0] = bus0.rd_count; assign rd_count_o[1] = bus1.rd_count;
    assign rd_data_o[0]  = bus0.rd_data;  assign rd_data_o[1]  = bus1.rd_data;

    // Stimulus only: one word into instance d, ending #1 after its write edge.
    task automatic write_word(input int d, input logic [7:0] val);
        @(posedge wr_clk); #1;
        wr_en_s[d] = 1'b1; wr_data_s[d] = val;
        @(posedge wr_clk); #1;
        wr_en_s[d] = 1'b0;
    endtask

    // Stimulus only: wait (bounded) for a readable word and pop it.
    task automatic read_one(input int d, output logic [7:0] data, output logic ok);
        int t = 0;
        @(posedge rd_clk); #1;
        while (t < 10 && (d == 0 ? rd_empty_o[d] : !rd_valid_o[d])) begin
            @(posedge rd_clk); #1; t++;
        end
        ok = 1'b0; data = 8'h00;
        if (t >= 10) return;
        if (d == 0) begin
            rd_en_s[d] = 1'b1;
            @(posedge rd_clk); #1;
            rd_en_s[d] = 1'b0;
            ok = rd_valid_o[d]; data = rd_data_o[d];
        end else begin
            data = rd_data_o[d]; ok = 1'b1;
            rd_en_s[d] = 1'b1;
            @(posedge rd_clk); #1;
            rd_en_s[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        wr_rstn = 1'b0; rd_rstn = 1'b0;
        repeat (3) @(posedge rd_clk);
        @(posedge wr_clk); #1;
        wr_rstn = 1'b1; rd_rstn = 1'b1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({wr_full_o[d], almost_full_o[d], wr_overflow_o[d], wr_count_o[d]} !== 8'b0) begin
                bad++; $display("FAIL reset_wr d=%0d got full=%b af=%b ovf=%b cnt=%0d want 0 0 0 0",
                                d, wr_full_o[d], almost_full_o[d], wr_overflow_o[d], wr_count_o[d]);
            end
            total++;
            if ({rd_empty_o[d], almost_empty_o[d], rd_valid_o[d], rd_underflow_o[d], rd_count_o[d], rd_data_o[d]} !== {4'b1100, 5'd0, 8'h00}) begin
                bad++; $display("FAIL reset_rd d=%0d got empty=%b ae=%b valid=%b unf=%b cnt=%0d data=%h want 1 1 0 0 0 00",
                                d, rd_empty_o[d], almost_empty_o[d], rd_valid_o[d], rd_underflow_o[d], rd_count_o[d], rd_data_o[d]);
            end
            $display("[reset] d=%0d checked", d);
        end
    endtask

    task automatic test_fill();
        int n;
        @(posedge wr_clk); #1;
        for (int i = 0; i < 17; i++) begin
            wr_en_s[0] = 1'b1; wr_data_s[0] = 8'(i);
            @(posedge wr_clk); #1;
            n = (i < 16) ? i + 1 : 16;
            total++;
            if (wr_count_o[0] !== 5'(n) || almost_full_o[0] !== (n >= 14) || wr_full_o[0] !== (n == 16)) begin
                bad++; $display("FAIL fill_status i=%0d got cnt=%0d af=%b full=%b want %0d %b %b",
                                i, wr_count_o[0], almost_full_o[0], wr_full_o[0], n, n >= 14, n == 16);
            end
            total++;
            if (wr_overflow_o[0] !== (i == 16)) begin
                bad++; $display("FAIL fill_overflow i=%0d got %b want %b", i, wr_overflow_o[0], i == 16);
            end
            $display("[fill] write %h count=%0d", 8'(i), wr_count_o[0]);
        end
        wr_en_s[0] = 1'b0;
        @(posedge wr_clk); #1;
        total++;
        if (wr_overflow_o[0] !== 1'b0) begin
            bad++; $display("FAIL overflow_pulse_len got %b want 0", wr_overflow_o[0]);
        end
        n = 0;
        @(posedge rd_clk); #1;
        while (n < 3 && rd_count_o[0] != 5'd16) begin @(posedge rd_clk); #1; n++; end
        total++;
        if (rd_count_o[0] !== 5'd16 || almost_empty_o[0] !== 1'b0) begin
            bad++; $display("FAIL fill_rd_count got cnt=%0d ae=%b want 16 0", rd_count_o[0], almost_empty_o[0]);
        end
        for (int i = 0; i < 16; i++) begin
            rd_en_s[0] = 1'b1;
            @(posedge rd_clk); #1;
            total++;
            if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== 8'(i) || rd_count_o[0] !== 5'(15 - i)
                || almost_empty_o[0] !== (15 - i <= 2)) begin
                bad++; $display("FAIL drain i=%0d got valid=%b data=%h cnt=%0d ae=%b want 1 %h %0d %b",
                                i, rd_valid_o[0], rd_data_o[0], rd_count_o[0], almost_empty_o[0], 8'(i), 15 - i, 15 - i <= 2);
            end
            $display("[fill] read %h", rd_data_o[0]);
        end
        rd_en_s[0] = 1'b0;
        total++;
        if (rd_empty_o[0] !== 1'b1) begin
            bad++; $display("FAIL drain_empty got %b want 1", rd_empty_o[0]);
        end
        n = 0;
        @(posedge wr_clk); #1;
        while (n < 4 && wr_count_o[0] != 5'd0) begin @(posedge wr_clk); #1; n++; end
        total++;
        if (wr_count_o[0] !== 5'd0 || wr_full_o[0] !== 1'b0) begin
            bad++; $display("FAIL drain_wr_side got cnt=%0d full=%b want 0 0", wr_count_o[0], wr_full_o[0]);
        end
    endtask

    task automatic test_std_read();
        int n = 0;
        @(posedge wr_clk); #1;
        wr_en_s[0] = 1'b1; wr_data_s[0] = 8'hA5;
        @(posedge wr_clk);
        fork begin #1; wr_en_s[0] = 1'b0; end join_none
        while (n < 3 && rd_empty_o[0]) begin @(posedge rd_clk); n++; #1; end
        total++;
        if (rd_empty_o[0] !== 1'b0) begin
            bad++; $display("FAIL std_latency got empty=%b after %0d edges want 0", rd_empty_o[0], n);
        end
        rd_en_s[0] = 1'b1;
        @(posedge rd_clk); #1;
        rd_en_s[0] = 1'b0;
        total++;
        if (rd_valid_o[0] !== 1'b1 || rd_data_o[0] !== 8'hA5 || rd_empty_o[0] !== 1'b1 || rd_count_o[0] !== 5'd0) begin
            bad++; $display("FAIL std_read got valid=%b data=%h empty=%b cnt=%0d want 1 a5 1 0",
                            rd_valid_o[0], rd_data_o[0], rd_empty_o[0], rd_count_o[0]);
        end
        $display("[std] read %h", rd_data_o[0]);
        @(posedge rd_clk); #1;
        total++;
        if (rd_valid_o[0] !== 1'b0 || rd_data_o[0] !== 8'hA5) begin
            bad++; $display("FAIL std_hold got valid=%b data=%h want 0 a5", rd_valid_o[0], rd_data_o[0]);
        end
    endtask

    task automatic test_fwft();
        int n = 0;
        @(posedge wr_clk); #1;
        wr_en_s[1] = 1'b1; wr_data_s[1] = 8'h3C;
        @(posedge wr_clk);
        fork begin #1; wr_en_s[1] = 1'b0; end join_none
        while (n < 4 && !rd_valid_o[1]) begin @(posedge rd_clk); n++; #1; end
        total++;
        if (rd_valid_o[1] !== 1'b1 || rd_data_o[1] !== 8'h3C || rd_count_o[1] !== 5'd1 || rd_empty_o[1] !== 1'b0) begin
            bad++; $display("FAIL fwft_fall got valid=%b data=%h cnt=%0d empty=%b want 1 3c 1 0",
                            rd_valid_o[1], rd_data_o[1], rd_count_o[1], rd_empty_o[1]);
        end
        $display("[fwft] head %h after %0d edges", rd_data_o[1], n);
        rd_en_s[1] = 1'b1;
        @(posedge rd_clk); #1;
        rd_en_s[1] = 1'b0;
        total++;
        if (rd_valid_o[1] !== 1'b0 || rd_empty_o[1] !== 1'b1 || rd_count_o[1] !== 5'd0) begin
            bad++; $display("FAIL fwft_pop got valid=%b empty=%b cnt=%0d want 0 1 0",
                            rd_valid_o[1], rd_empty_o[1], rd_count_o[1]);
        end
    endtask

    task automatic test_underflow();
        logic [7:0] data;
        logic ok;
        for (int d = 0; d < 2; d++) begin
            @(posedge rd_clk); #1;
            rd_en_s[d] = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(posedge rd_clk); #1;
                total++;
                if (rd_underflow_o[d] !== 1'b1) begin
                    bad++; $display("FAIL underflow d=%0d i=%0d got %b want 1", d, i, rd_underflow_o[d]);
                end
            end
            rd_en_s[d] = 1'b0;
            @(posedge rd_clk); #1;
            total++;
            if (rd_underflow_o[d] !== 1'b0 || rd_count_o[d] !== 5'd0) begin
                bad++; $display("FAIL underflow_end d=%0d got unf=%b cnt=%0d want 0 0", d, rd_underflow_o[d], rd_count_o[d]);
            end
            write_word(d, 8'h77);
            read_one(d, data, ok);
            total++;
            if (ok !== 1'b1 || data !== 8'h77) begin
                bad++; $display("FAIL underflow_recover d=%0d got ok=%b data=%h want 1 77", d, ok, data);
            end
            $display("[underflow] d=%0d read %h", d, data);
        end
    endtask

    task automatic test_stream(input int d);
        int k = 0;
        int ovf = 0;
        int unf = 0;
        exp_q.delete();
        fork
            begin
                int n = 0;
                int cyc = 0;
                @(posedge wr_clk); #1;
                while (n < 100 && cyc < 3000) begin
                    if ($urandom_range(1, 0) == 1 && !wr_full_o[d]) begin
                        wr_en_s[d] = 1'b1; wr_data_s[d] = 8'(n);
                        exp_q.push_back(8'(n)); n++;
                    end else begin
                        wr_en_s[d] = 1'b0;
                    end
                    @(posedge wr_clk); #1; cyc++;
                    if (wr_overflow_o[d]) ovf++;
                end
                wr_en_s[d] = 1'b0;
            end
            begin
                int cyc = 0;
                logic [7:0] want;
                @(posedge rd_clk); #1;
                while (k < 100 && cyc < 6000) begin
                    if (rd_underflow_o[d]) unf++;
                    if (d == 0) begin
                        if (rd_valid_o[d]) begin
                            want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                            total++;
                            if (rd_data_o[d] !== want) begin
                                bad++; $display("FAIL stream d=%0d k=%0d got %h want %h", d, k, rd_data_o[d], want);
                            end
                            $display("[stream] d=%0d read %h", d, rd_data_o[d]);
                            k++;
                        end
                        rd_en_s[d] = (k < 100) && $urandom_range(1, 0) == 1 && !rd_empty_o[d];
                    end else begin
                        rd_en_s[d] = 1'b0;
                        if ($urandom_range(1, 0) == 1 && rd_valid_o[d]) begin
                            want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                            total++;
                            if (rd_data_o[d] !== want) begin
                                bad++; $display("FAIL stream d=%0d k=%0d got %h want %h", d, k, rd_data_o[d], want);
                            end
                            $display("[stream] d=%0d read %h", d, rd_data_o[d]);
                            rd_en_s[d] = 1'b1; k++;
                        end
                    end
                    @(posedge rd_clk); #1; cyc++;
                end
                if (rd_underflow_o[d]) unf++;
                rd_en_s[d] = 1'b0;
            end
        join
        total++;
        if (k !== 100 || ovf !== 0 || unf !== 0) begin
            bad++; $display("FAIL stream_summary d=%0d got reads=%0d ovf=%0d unf=%0d want 100 0 0", d, k, ovf, unf);
        end
        repeat (5) @(posedge rd_clk);
        repeat (5) @(posedge wr_clk);
        #1;
        total++;
        if (rd_count_o[d] !== 5'd0 || rd_empty_o[d] !== 1'b1 || wr_count_o[d] !== 5'd0) begin
            bad++; $display("FAIL stream_drained d=%0d got rcnt=%0d empty=%b wcnt=%0d want 0 1 0",
                            d, rd_count_o[d], rd_empty_o[d], wr_count_o[d]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] data;
        logic ok;
        @(posedge wr_clk); #1;
        for (int i = 0; i < 7; i++) begin
            wr_en_s = 2'b11; wr_data_s[0] = 8'($urandom); wr_data_s[1] = 8'($urandom);
            @(posedge wr_clk); #1;
        end
        wr_en_s = 2'b00;
        repeat (6) @(posedge rd_clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (rd_count_o[d] !== 5'd7) begin
                bad++; $display("FAIL queued7 d=%0d got %0d want 7", d, rd_count_o[d]);
            end
        end
        @(posedge wr_clk); #1;
        wr_rstn = 1'b0; rd_rstn = 1'b0;
        repeat (2) @(posedge wr_clk);
        repeat (2) @(posedge rd_clk);
        @(posedge wr_clk); #1;
        wr_rstn = 1'b1; rd_rstn = 1'b1;
        for (int d = 0; d < 2; d++) begin
            total++;
            if (wr_count_o[d] !== 5'd0 || rd_count_o[d] !== 5'd0 || rd_empty_o[d] !== 1'b1
                || wr_full_o[d] !== 1'b0 || rd_valid_o[d] !== 1'b0) begin
                bad++; $display("FAIL reset_mid d=%0d got wcnt=%0d rcnt=%0d empty=%b full=%b valid=%b want 0 0 1 0 0",
                                d, wr_count_o[d], rd_count_o[d], rd_empty_o[d], wr_full_o[d], rd_valid_o[d]);
            end
            write_word(d, 8'h55);
            read_one(d, data, ok);
            total++;
            if (ok !== 1'b1 || data !== 8'h55) begin
                bad++; $display("FAIL reset_mid_read d=%0d got ok=%b data=%h want 1 55", d, ok, data);
            end
            $display("[reset_mid] d=%0d read %h", d, data);
        end
    endtask

    initial begin
        wr_en_s = 2'b00; rd_en_s = 2'b00;
        wr_data_s[0] = 8'h00; wr_data_s[1] = 8'h00;
        test_reset();
        test_fill();
        test_std_read();
        test_fwft();
        test_underflow();
        test_stream(0);
        test_stream(1);
        wr_half = 8.5; rd_half = 5.0;
        repeat (4) @(posedge wr_clk);
        test_stream(0);
        test_stream(1);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
